conv_window_sequencer: RTL
==========================

// Module: conv_window_sequencer
// PURPOSE
//  Parametrised controller for a KxK sliding-window convolution over a zero-padded image held in RAM.
//  Raster-scans every output pixel. For each one it fetches the KxK window from RAM and strobes the window
//  shift register once per returned pixel, then starts the conv engine and waits for its completion.
//  Sits between the image RAM (address side) and the conv datapath (shift_right/start_conv/done_conv).
// PARAMETERS
//  IMG_W   128  unpadded image width (pixels)
//  IMG_H   128  unpadded image height (pixels)
//  K       3    kernel size; odd, >=1; padding P=(K-1)/2 on every side
//  STRIDE  1    output step in rows and columns, >=1
//  RD_LAT  1    RAM read latency in cycles, 0..7
//  Derived localparams:
//    PW=IMG_W+2P, PH=IMG_H+2P
//    OUT_W=(PW-K)/STRIDE+1, OUT_H=(PH-K)/STRIDE+1
//    ADDR_W=$clog2(PW*PH)  (defaults: PW=130, ADDR_W=15)
// PORTS
//  clk            in   1       rising-edge clock
//  rst_n          in   1       synchronous reset, active-low
//  start          in   1       level; sampled only in IDLE
//  done_conv      in   1       conv engine finished current window; sampled only in WAIT
//  address        out  ADDR_W  RAM read address, valid when addr_valid=1
//  addr_valid     out  1       RAM read enable
//  shift_right    out  1       window shift strobe = addr_valid delayed RD_LAT cycles
//  start_conv     out  1       one-cycle pulse per window
//  out_row        out  16      output row index of current window
//  out_col        out  16      output col index of current window
//  busy           out  1       1 in every state except IDLE
//  done           out  1       one-cycle pulse after last window completes
//  current_state  out  3       state encoding, debug
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE; all outputs, counters and the shift delay line go to 0. Applies from any state.
//  States and transitions:
//    IDLE : start=1 -> FETCH with out_row=out_col=ki=kj=0; else stay.
//    FETCH: exactly K*K cycles, addr_valid=1.
//           address = (out_row*STRIDE+ki)*PW + (out_col*STRIDE+kj).
//           kj increments 0..K-1, then ki increments (row-major order).
//           After the last element -> DRAIN, or -> CONV if RD_LAT=0.
//    DRAIN: RD_LAT cycles, addr_valid=0; lets the last shift_right pulse complete -> CONV.
//    CONV : start_conv=1 for this single cycle -> WAIT.
//    WAIT : done_conv=1 -> ADV; else stay (no timeout).
//    ADV  : one cycle.
//           If out_col<OUT_W-1: out_col++.
//           Else if out_row<OUT_H-1: out_col=0, out_row++.
//           Else -> FIN.
//           Otherwise -> FETCH.
//    FIN  : done=1 for one cycle; out_row/out_col hold last window -> IDLE.
//  Timing:
//    start sampled at edge t -> first addr_valid during cycle t+1.
//    i-th shift_right exactly RD_LAT cycles after the i-th addr_valid; K*K shift pulses per window, never more.
//  Width rules:
//    address computed at ADDR_W bits, unsigned, never exceeds PW*PH-1 (padding removes negative offsets).
//    out_row/out_col zero-extended to 16 bits.
//  Ignored inputs:
//    start outside IDLE; done_conv outside WAIT, including done_conv asserted during CONV.
//    start still high in the cycle after FIN begins a new frame from IDLE on the next edge.
//  Row/column order: out_col wraps to 0 only when out_row advances. out_row is never cleared mid-frame.
// STRUCTURE
//  conv_ctrl_pkg: state enum (IDLE,FETCH,DRAIN,CONV,WAIT,ADV,FIN as 3'd0..6); helper function to derive PW/OUT_W/ADDR_W.
//  Sub-module window_addr_gen: ki/kj counters plus base-address accumulator.
//    Base row offset is updated by adding PW*STRIDE per row; no multiplier in the per-cycle path.
//    Provides last_elem flag.
//  Top level holds the FSM, out_row/out_col counters, and the RD_LAT-deep shift_right delay line.
// TESTING
//  1 Defaults, start pulse, done_conv 3 cyc after start_conv:
//    addresses 0,1,2,130,131,132,260,261,262 on 9 consecutive cycles.
//    9 shift_right pulses each 1 cycle later. start_conv rises 1 cycle after last shift_right.
//  2 Defaults, full frame, done_conv tied 1:
//    16384 start_conv pulses; last window base address 16637; done pulses once; busy falls the next cycle.
//  3 Defaults, row wrap: window after (out_row=0,out_col=127) is (1,0) with first address 130.
//  4 IMG_W=IMG_H=8, K=3, STRIDE=2:
//    16 windows (4x4); window (1,1) first address 22, last address 44.
//  5 rst_n=0 in 5th FETCH cycle:
//    next cycle address=0, all strobes 0, state IDLE.
//    Next start restarts at (0,0), address 0. No stale shift_right from the delay line.
//  6 RD_LAT=0 and RD_LAT=3:
//    shift_right count=K*K with lag 0 / 3 cycles.
//    start held high while busy causes no restart; done_conv pulse during FETCH ignored.

Source files
------------

// File: rtl/conv_window_sequencer_pkg.sv
// Shared state encoding and geometry helpers for the KxK convolution window sequencer.
package conv_window_sequencer_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_FETCH = 3'd1;
    localparam state_t ST_DRAIN = 3'd2;
    localparam state_t ST_CONV  = 3'd3;
    localparam state_t ST_WAIT  = 3'd4;
    localparam state_t ST_ADV   = 3'd5;
    localparam state_t ST_FIN   = 3'd6;

    // Image dimension after zero padding of (K-1)/2 on both sides.
    function automatic int padded_dim(input int dim, input int k);
        return dim + (k - 1);
    endfunction

    // Number of window positions along one axis.
    function automatic int out_dim(input int dim, input int k, input int stride);
        return (padded_dim(dim, k) - k) / stride + 1;
    endfunction

    // Address width able to reach every pixel of the padded image (at least 1 bit).
    function automatic int addr_width(input int pw, input int ph);
        return (pw * ph > 1) ? $clog2(pw * ph) : 1;
    endfunction

endpackage

// File: rtl/conv_window_sequencer_addr_gen.sv
// Window address generator: walks the KxK window row-major using adders only.
// The window base advances by STRIDE per column and by PW*STRIDE per output row.
module window_addr_gen
    import conv_window_sequencer_pkg::*;
#(
    parameter int PW     = 130,
    parameter int K      = 3,
    parameter int STRIDE = 1,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              step,
    input  logic              col_adv,
    input  logic              row_adv,
    output logic [ADDR_W-1:0] address,
    output logic              last_elem
);

    localparam int              KW       = (K > 1) ? $clog2(K) : 1;
    localparam logic [KW-1:0]   K_LAST   = KW'(K - 1);
    localparam logic [ADDR_W-1:0] PW_STEP  = ADDR_W'(PW);
    localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(PW * STRIDE);

    logic [KW-1:0]     ki_q, ki_d;
    logic [KW-1:0]     kj_q, kj_d;
    logic [ADDR_W-1:0] row_off_q, row_off_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] win_base_q, win_base_d;

    // Next-state for the in-window counters and the window base accumulators.
    always_comb begin
        ki_d       = ki_q;
        kj_d       = kj_q;
        row_off_d  = row_off_q;
        row_base_d = row_base_q;
        win_base_d = win_base_q;

        if (step) begin
            if (kj_q == K_LAST) begin
                kj_d = '0;
                if (ki_q == K_LAST) begin
                    ki_d      = '0;
                    row_off_d = '0;
                end else begin
                    ki_d      = ki_q + KW'(1);
                    row_off_d = row_off_q + PW_STEP;
                end
            end else begin
                kj_d = kj_q + KW'(1);
            end
        end

        if (col_adv) begin
            win_base_d = win_base_q + COL_STEP;
        end else if (row_adv) begin
            row_base_d = row_base_q + ROW_STEP;
            win_base_d = row_base_q + ROW_STEP;
        end

        if (clear) begin
            ki_d       = '0;
            kj_d       = '0;
            row_off_d  = '0;
            row_base_d = '0;
            win_base_d = '0;
        end
    end

    // Counter and accumulator registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ki_q       <= '0;
            kj_q       <= '0;
            row_off_q  <= '0;
            row_base_q <= '0;
            win_base_q <= '0;
        end else begin
            ki_q       <= ki_d;
            kj_q       <= kj_d;
            row_off_q  <= row_off_d;
            row_base_q <= row_base_d;
            win_base_q <= win_base_d;
        end
    end

    assign address   = win_base_q + row_off_q + ADDR_W'(kj_q);
    assign last_elem = (ki_q == K_LAST) && (kj_q == K_LAST);

endmodule

// File: rtl/conv_window_sequencer.sv
// Convolution window sequencer: raster-scans output pixels, fetches each KxK window
// from RAM, strobes the window shift register as data returns, then hands off to the
// conv engine and waits for its completion before moving to the next window.
module conv_window_sequencer
    import conv_window_sequencer_pkg::*;
#(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int K      = 3,
    parameter int STRIDE = 1,
    parameter int RD_LAT = 1,
    localparam int PW     = padded_dim(IMG_W, K),
    localparam int PH     = padded_dim(IMG_H, K),
    localparam int OUT_W  = out_dim(IMG_W, K, STRIDE),
    localparam int OUT_H  = out_dim(IMG_H, K, STRIDE),
    localparam int ADDR_W = addr_width(PW, PH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              done_conv,
    output logic [ADDR_W-1:0] address,
    output logic              addr_valid,
    output logic              shift_right,
    output logic              start_conv,
    output logic [15:0]       out_row,
    output logic [15:0]       out_col,
    output logic              busy,
    output logic              done,
    output logic [2:0]        current_state
);

    localparam logic [15:0] COL_LAST   = 16'(OUT_W - 1);
    localparam logic [15:0] ROW_LAST   = 16'(OUT_H - 1);
    localparam logic [2:0]  DRAIN_LAST = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;
    localparam state_t      FETCH_NEXT = (RD_LAT == 0) ? ST_CONV : ST_DRAIN;

    state_t      state_q, state_d;
    logic [15:0] out_row_q, out_row_d;
    logic [15:0] out_col_q, out_col_d;
    logic [2:0]  drain_q, drain_d;

    logic clear;
    logic col_adv;
    logic row_adv;
    logic last_elem;

    window_addr_gen #(
        .PW     (PW),
        .K      (K),
        .STRIDE (STRIDE),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .step      (addr_valid),
        .col_adv   (col_adv),
        .row_adv   (row_adv),
        .address   (address),
        .last_elem (last_elem)
    );

    // Sequencer FSM plus output-pixel raster counters.
    always_comb begin
        state_d   = state_q;
        out_row_d = out_row_q;
        out_col_d = out_col_q;
        drain_d   = drain_q;
        clear     = 1'b0;
        col_adv   = 1'b0;
        row_adv   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_FETCH;
                    out_row_d = '0;
                    out_col_d = '0;
                    clear     = 1'b1;
                end
            end
            ST_FETCH: begin
                if (last_elem) begin
                    state_d = FETCH_NEXT;
                    drain_d = '0;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_CONV;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            ST_CONV: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_conv) begin
                    state_d = ST_ADV;
                end
            end
            ST_ADV: begin
                if (out_col_q < COL_LAST) begin
                    out_col_d = out_col_q + 16'd1;
                    col_adv   = 1'b1;
                    state_d   = ST_FETCH;
                end else if (out_row_q < ROW_LAST) begin
                    out_col_d = '0;
                    out_row_d = out_row_q + 16'd1;
                    row_adv   = 1'b1;
                    state_d   = ST_FETCH;
                end else begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and raster counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            out_row_q <= '0;
            out_col_q <= '0;
            drain_q   <= '0;
        end else begin
            state_q   <= state_d;
            out_row_q <= out_row_d;
            out_col_q <= out_col_d;
            drain_q   <= drain_d;
        end
    end

    // shift_right mirrors addr_valid after the RAM read latency.
    generate
        if (RD_LAT == 0) begin : g_no_delay
            assign shift_right = addr_valid;
        end else begin : g_delay
            logic [RD_LAT-1:0] sr_q, sr_d;

            // Shift the read strobe along the latency line.
            always_comb begin
                sr_d    = sr_q << 1;
                sr_d[0] = addr_valid;
            end

            // Latency line register; cleared so no stale strobe survives a reset.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sr_q <= '0;
                end else begin
                    sr_q <= sr_d;
                end
            end

            assign shift_right = sr_q[RD_LAT-1];
        end
    endgenerate

    assign addr_valid    = (state_q == ST_FETCH);
    assign start_conv    = (state_q == ST_CONV);
    assign done          = (state_q == ST_FIN);
    assign busy          = (state_q != ST_IDLE);
    assign out_row       = out_row_q;
    assign out_col       = out_col_q;
    assign current_state = state_q;

endmodule
